// File: rtl/divide_logic.sv
// divide_logic: iterative RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring,
// one quotient bit per cycle.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow are
// detected at acceptance and skip the iterative phase.
module divide_logic #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             flush,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic             is_rem_q, is_rem_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic             divz_q, divz_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d;

    // Operand decode at acceptance: signed ops work on magnitudes.
    logic             signed_in, neg_a, neg_b, divz_in, ovf_in, accept;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign signed_in = ~op[0];
    assign neg_a     = signed_in & in_a[WIDTH-1];
    assign neg_b     = signed_in & in_b[WIDTH-1];
    assign mag_a     = neg_a ? -in_a : in_a;
    assign mag_b     = neg_b ? -in_b : in_b;
    assign divz_in   = (in_b == '0);
    assign ovf_in    = signed_in && (in_a == MIN_NEG) && (in_b == '1);
    assign accept    = (state_q == IDLE) && start && !flush;

    // One restoring step. The bit shifted out of rem is kept in the compare so
    // divisors above 2^(WIDTH-1) still divide correctly; when the subtract is
    // taken the true difference is below the divisor and fits in WIDTH bits.
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, dvs_q});
    assign diff    = shifted[WIDTH-1:0] - dvs_q;

    // Sign fix-up and RISC-V special cases, evaluated while in FIX.
    logic [WIDTH-1:0] q_fix, r_fix;

    always_comb begin
        q_fix = (sa_q ^ sb_q) ? -dvd_q : dvd_q;
        r_fix = sa_q ? -rem_q : rem_q;
        if (divz_q) begin
            q_fix = '1;
            r_fix = a_q;
        end else if (ovf_q) begin
            q_fix = MIN_NEG;
            r_fix = '0;
        end
    end

    // FSM next state: flush squashes CALC/FIX and drops a same-cycle request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef DIV_EARLY_OUT_EN
                    state_d = (divz_in || ovf_in) ? FIX : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                if (flush)            state_d = IDLE;
                else if (cnt_q == '0) state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next state: latch on accept, iterate in CALC, publish in FIX.
    always_comb begin
        is_rem_d = is_rem_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        divz_d   = divz_q;
        ovf_d    = ovf_q;
        a_d      = a_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        done_d   = 1'b0;
        if (accept) begin
            is_rem_d = op[1];
            sa_d     = neg_a;
            sb_d     = neg_b;
            divz_d   = divz_in;
            ovf_d    = ovf_in;
            a_d      = in_a;
            dvd_d    = mag_a;
            dvs_d    = mag_b;
            rem_d    = '0;
            cnt_d    = CW'(WIDTH - 1);
        end else if (state_q == CALC && !flush) begin
            rem_d = ge ? diff : shifted[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], ge};
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end else if (state_q == FIX && !flush) begin
            res_d  = is_rem_q ? r_fix : q_fix;
            done_d = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            is_rem_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            divz_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_q      <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            is_rem_q <= is_rem_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            divz_q   <= divz_d;
            ovf_q    <= ovf_d;
            a_q      <= a_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            done_q   <= done_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign res   = res_q;
endmodule

// File: tb/tb_divide_logic.sv
// tb_divide_logic: scoreboard bench for divide_logic (RV32M semantics model).
module tb_divide_logic;
    localparam logic [31:0] MINV = 32'h8000_0000;
    localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;
`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST, start, flush, ready, done;
    logic [1:0]  op;
    logic [31:0] in_a, in_b, res;

    divide_logic #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
        .flush(flush), .ready(ready), .done(done), .res(res)
    );

    always #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] sb[$];
    logic [31:0] last_res = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) begin
            q = ALL1; r = a;
        end else if (!o[0]) begin
            if (a == MINV && b == ALL1) begin
                q = MINV; r = 0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b; r = a % b;
        end
        return o[1] ? r : q;
    endfunction

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // Issue one op (caller guarantees ready), wait for done, score it.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit intrude);
        int cyc, lat;
        bit special;
        logic [31:0] e;
        e = model(o, a, b);
        sb.push_back(e);
        special = (b == 0) || (!o[0] && a == MINV && b == ALL1);
        lat = (EARLY && special) ? 2 : 34;
        op = o; in_a = a; in_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        check({tag, "/busy"}, {31'b0, ready}, 32'd0);
        check({tag, "/nodone"}, {31'b0, done}, 32'd0);
        while (!done && cyc < 100) begin
            start = intrude && (cyc == 5);
            if (start) begin in_a = 32'd1234; in_b = 32'd5; op = 2'b00; end
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, "/lat"}, cyc, lat);
        check({tag, "/res"}, res, sb.pop_front());
        check({tag, "/rdy"}, {31'b0, ready}, 32'd1);
        last_res = e;
    endtask

    // DIVU 100/7 squashed by flush during cycle `at`; no result may appear.
    task automatic flush_op(input string tag, input int at);
        int cyc;
        bit seen;
        op = 2'b01; in_a = 32'd100; in_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        seen = 1'b0;
        while (cyc < at) begin
            start = (cyc == 5);
            seen |= done;
            tick();
            cyc++;
        end
        start = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check({tag, "/rdy"}, {31'b0, ready}, 32'd1);
        check({tag, "/res"}, res, last_res);
        repeat (40) begin seen |= done; tick(); end
        check({tag, "/nodone"}, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        bit seen;
        RST = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; in_a = '0; in_b = '0;
        tick(); tick();
        check("rst/rdy", {31'b0, ready}, 32'd1);
        check("rst/done", {31'b0, done}, 32'd0);
        check("rst/res", res, 32'd0);
        RST = 1'b0;
        tick();

        // Directed cases, issued back-to-back in each done cycle.
        run_op("divu", 2'b01, 32'd100, 32'd7, 1'b0);
        run_op("remu", 2'b11, 32'd100, 32'd7, 1'b0);
        run_op("div_neg", 2'b00, -32'sd7, 32'd2, 1'b0);
        run_op("rem_neg", 2'b10, -32'sd7, 32'd2, 1'b0);
        run_op("div_ovf", 2'b00, MINV, ALL1, 1'b0);
        run_op("rem_ovf", 2'b10, MINV, ALL1, 1'b0);
        run_op("divu_z", 2'b01, 32'd5, 32'd0, 1'b0);
        run_op("rem_z", 2'b10, -32'sd5, 32'd0, 1'b0);
        run_op("div_z", 2'b00, -32'sd5, 32'd0, 1'b0);
        run_op("divu_big", 2'b01, ALL1, 32'h8000_0001, 1'b0);
        run_op("remu_big", 2'b11, 32'hFFFF_FFFE, ALL1, 1'b0);
        run_op("intrude", 2'b01, 32'd100, 32'd7, 1'b1);

        // Random mix.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            run_op("rand", 2'($urandom_range(0, 3)), ra, rb, 1'b0);
        end

        // Squash in CALC and in FIX.
        flush_op("flush10", 10);
        flush_op("flush_fix", 33);

        // start+flush together in IDLE: request dropped.
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("sf_idle/rdy", {31'b0, ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin seen |= done; tick(); end
        check("sf_idle/nodone", {31'b0, seen}, 32'd0);

        // Reset mid-op, then a fresh op.
        op = 2'b01; in_a = 32'd100; in_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_mid/rdy", {31'b0, ready}, 32'd1);
        check("rst_mid/done", {31'b0, done}, 32'd0);
        check("rst_mid/res", res, 32'd0);
        run_op("after_rst", 2'b01, 32'd9, 32'd3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
